synth_i2s_tx: RTL and testbench
===============================

SYNTH_I2S_TX -- requirements
Module: synth_i2s_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 12, the width of the signed mixed-sample input.
REQ-002 SHALL have parameter SLOT_BITS, default 16, the number of bclk periods per channel slot; legal range is SLOT_BITS >= DATA_BITS+1.
REQ-003 SHALL have parameter CLK_DIV, default 2, the number of clk cycles per bclk half-period; legal range is CLK_DIV >= 1.
REQ-004 SHALL have port clk, input, 1 bit: system clock, rising-edge active, and the only clock.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: requests serial output.
REQ-007 SHALL have port din, input, signed DATA_BITS bits: the saturated sample from the synth mixer dout.
REQ-008 SHALL have port bclk, output, 1 bit: the bit clock to the DAC.
REQ-009 SHALL have port lrclk, output, 1 bit: word select; 0 selects the left slot and 1 the right slot.
REQ-010 SHALL have port sdata, output, 1 bit: serial data.
REQ-011 SHALL have port sample_strobe, output, 1 bit: a 1-cycle pulse in the cycle din is latched.
REQ-012 SHALL register all outputs, with no combinational path from inputs to outputs.

Function
REQ-013 SHALL implement three states: IDLE, RUN and DRAIN.
REQ-014 IDLE SHALL move to RUN when enable=1, and the transition cycle SHALL clear div_cnt and bit_cnt, latch din and pulse sample_strobe.
REQ-015 RUN SHALL move to DRAIN when enable=0.
REQ-016 DRAIN SHALL return to RUN if enable=1, with no gap in the frame.
REQ-017 DRAIN SHALL move to IDLE at the end of the frame, with no latch and no strobe.
REQ-018 In RUN and DRAIN, div_cnt SHALL count 0..CLK_DIV-1, and bclk SHALL toggle on wrap, giving a bclk period of 2*CLK_DIV clk cycles and a 50% duty cycle.
REQ-019 Each bclk falling transition SHALL advance bit_cnt modulo 2*SLOT_BITS.
REQ-020 End of frame SHALL be the bclk falling transition where bit_cnt wraps from 2*SLOT_BITS-1 to 0.
REQ-021 At end of frame in RUN, din SHALL be latched and sample_strobe pulsed in the same cycle, and the new sample SHALL be used from bit_cnt=0.
REQ-022 lrclk SHALL be 1 when bit_cnt >= SLOT_BITS and 0 otherwise, and SHALL change only on bclk falling transitions.
REQ-023 Within each slot, with p = bit_cnt mod SLOT_BITS, sdata SHALL equal sample bit DATA_BITS-p for p = 1..DATA_BITS (MSB first, one bclk after the lrclk edge), and 0 for p = 0 and for p > DATA_BITS.
REQ-024 The left and right slots SHALL carry the same latched sample (mono).
REQ-025 sdata SHALL change only on bclk falling transitions.
REQ-026 din SHALL be sampled only in strobe cycles, and changes to din at any other time SHALL not affect the frame in progress.
REQ-027 The latency from the strobe cycle to the first MSB on sdata SHALL be 2*CLK_DIV clk cycles.
REQ-028 In IDLE, bclk, lrclk, sdata and sample_strobe SHALL be held at 0.
REQ-029 A one-cycle enable pulse in IDLE SHALL produce one complete frame followed by IDLE.
REQ-030 When enable falls and rises again within the same frame, the output SHALL be identical to enable held at 1.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, div_cnt=0, bit_cnt=0, sample register=0, bclk=0, lrclk=0, sdata=0 and sample_strobe=0, regardless of clk.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no completion.
REQ-033 After reset_n rises, the first frame SHALL start only on enable=1, following REQ-014.

Verification (DATA_BITS=12, SLOT_BITS=16, CLK_DIV=2: bclk period 4 clk, frame 128 clk)
REQ-034 A bench SHALL cover: reset, then enable=1 with din=12'hA5C held -> strobe in cycle 0, first bclk rise at cycle 2, left slot sdata = 0,1010_0101_1100,000, right slot identical, lrclk high for bit_cnt 16..31, next strobe at cycle 128.
REQ-035 A bench SHALL cover: din=12'h800 (-2048) then 12'h7FF on the next strobe -> frame 1 slot bits 1..12 = 1000_0000_0000, frame 2 = 0111_1111_1111, no sign extension into the padding bits.
REQ-036 A bench SHALL cover: enable dropped at cycle 40 -> frame completes, bclk/lrclk/sdata=0 from cycle 128, no second strobe.
REQ-037 A bench SHALL cover: enable dropped at cycle 40 and restored at cycle 60 -> waveform identical to continuous enable, strobe at cycle 128.
REQ-038 A bench SHALL cover: reset_n pulsed low asynchronously at cycle 70, between clk edges -> all outputs 0 before the next clk edge, and with enable still 1 the next strobe 1 cycle after reset_n rises.
REQ-039 A bench SHALL cover: din toggled every cycle between strobes -> sdata reflects only the value present in the strobe cycle.

Source files
------------

// File: rtl/synth_i2s_tx.sv
// Mono I2S transmitter for the synth mixer: serialises one latched signed sample
// into both left and right slots, MSB one bclk after the word-select edge.
module synth_i2s_tx #(
  parameter int DATA_BITS = 12,
  parameter int SLOT_BITS = 16,
  parameter int CLK_DIV   = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic signed [DATA_BITS-1:0] din,
  output logic                        bclk,
  output logic                        lrclk,
  output logic                        sdata,
  output logic                        sample_strobe
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LEN  = BIT_W'(DATA_BITS);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t               state_r, state_s;
  logic [DIV_W-1:0]     div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0]     bit_cnt_r, bit_cnt_s;
  logic [DATA_BITS-1:0] sample_r, sample_s;
  logic                 bclk_r, bclk_s;
  logic                 lrclk_r, lrclk_s;
  logic                 sdata_r, sdata_s;
  logic                 strobe_r, strobe_s;
  logic                 wrap_s, fall_s, eof_s;
  logic [BIT_W-1:0]     bit_inc_s;

  // Slot position 0 and positions past the sample are padding zeros (no sign extension).
  function automatic logic slot_bit(input logic [DATA_BITS-1:0] s, input logic [BIT_W-1:0] frame_pos);
    logic [BIT_W-1:0]     pos;
    logic [DATA_BITS-1:0] shifted;
    logic                 r;
    pos = (frame_pos >= SLOT_LEN) ? (frame_pos - SLOT_LEN) : frame_pos;
    if ((pos != {BIT_W{1'b0}}) && (pos <= DATA_LEN)) begin
      shifted = s << (pos - BIT_W'(1));
      r       = shifted[DATA_BITS-1];
    end else begin
      shifted = {DATA_BITS{1'b0}};
      r       = 1'b0;
    end
    return r;
  endfunction

  // Next-state, counter and output-register logic.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    sample_s  = sample_r;
    bclk_s    = bclk_r;
    lrclk_s   = lrclk_r;
    sdata_s   = sdata_r;
    strobe_s  = 1'b0;
    wrap_s    = (div_cnt_r == DIV_LAST);
    fall_s    = wrap_s & bclk_r;
    eof_s     = fall_s & (bit_cnt_r == BIT_LAST);
    bit_inc_s = eof_s ? {BIT_W{1'b0}} : (bit_cnt_r + BIT_W'(1));
    case (state_r)
      ST_IDLE: begin
        div_cnt_s = {DIV_W{1'b0}};
        bit_cnt_s = {BIT_W{1'b0}};
        bclk_s    = 1'b0;
        lrclk_s   = 1'b0;
        sdata_s   = 1'b0;
        if (enable) begin
          state_s  = ST_RUN;
          sample_s = din;
          strobe_s = 1'b1;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        div_cnt_s = wrap_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
        if (wrap_s) begin
          bclk_s = ~bclk_r;
        end else begin
          bclk_s = bclk_r;
        end
        if (fall_s) begin
          bit_cnt_s = bit_inc_s;
          lrclk_s   = (bit_inc_s >= SLOT_LEN);
          sdata_s   = slot_bit(sample_r, bit_inc_s);
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
        // Re-enabling during drain resumes the frame exactly as if enable never fell.
        if (eof_s && ((state_r == ST_RUN) || enable)) begin
          sample_s = din;
          strobe_s = 1'b1;
        end else begin
          sample_s = sample_r;
        end
        if (enable) begin
          state_s = ST_RUN;
        end else if ((state_r == ST_DRAIN) && eof_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        div_cnt_s = {DIV_W{1'b0}};
        bit_cnt_s = {BIT_W{1'b0}};
        bclk_s    = 1'b0;
        lrclk_s   = 1'b0;
        sdata_s   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      sample_r  <= {DATA_BITS{1'b0}};
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      sdata_r   <= 1'b0;
      strobe_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      sample_r  <= sample_s;
      bclk_r    <= bclk_s;
      lrclk_r   <= lrclk_s;
      sdata_r   <= sdata_s;
      strobe_r  <= strobe_s;
    end
  end

  assign bclk          = bclk_r;
  assign lrclk         = lrclk_r;
  assign sdata         = sdata_r;
  assign sample_strobe = strobe_r;

endmodule

// File: tb/tb_synth_i2s_tx.sv
// Directed bench for synth_i2s_tx at default parameters (bclk period 4 clk, frame 128 clk).
module tb_synth_i2s_tx;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic signed [11:0] din = 12'sd0;
  logic               bclk, lrclk, sdata, sample_strobe;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int         cyc;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[15];

  synth_i2s_tx dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .din(din),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .sample_strobe(sample_strobe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int c, input logic [3:0] got, input logic [3:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d {bclk,lrclk,sdata,strobe} got=%b want=%b", name, c, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {bclk, lrclk, sdata, sample_strobe};
  endfunction

  // Reference waveform: t is the clk cycle within the frame, cycle 0 is the strobe cycle.
  function automatic logic [3:0] model(input int t, input logic [11:0] s);
    int   bitn, p;
    logic b, l, d, st;
    bitn = t / 4;
    p    = bitn % 16;
    b    = ((t % 4) >= 2);
    l    = (bitn >= 16);
    d    = (p >= 1 && p <= 12) ? s[12-p] : 1'b0;
    st   = (t == 0);
    return {b, l, d, st};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    din     = 12'sd0;
    #1;
    check("reset_async", 0, outs(), 4'b0000);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();
    check("idle_after_reset", 0, outs(), 4'b0000);
  endtask

  task automatic start(input logic [11:0] s0);
    do_reset();
    enable = 1'b1;
    din    = s0;
    step();
  endtask

  // Entered in cycle 0; frame 0 carries s0, later frames carry s1.
  task automatic run_scenario(input string name, input logic [11:0] s0, input logic [11:0] s1,
                              input int drop_at, input int restore_at, input bit toggle,
                              input int idle_from, input int last);
    logic [3:0] exp;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) step();
      if (c >= idle_from) exp = 4'b0000;
      else exp = model(c % 128, (c < 128) ? s0 : s1);
      check(name, c, outs(), exp);
      if (c == drop_at) enable = 1'b0;
      if (c == restore_at) enable = 1'b1;
      if (toggle) din = (c == 127) ? s1 : 12'($urandom);
      else if (c == 0) din = s1;
    end
  endtask

  initial begin
    tbl[0]  = '{0,   4'b0001};
    tbl[1]  = '{2,   4'b1000};
    tbl[2]  = '{4,   4'b0010};
    tbl[3]  = '{8,   4'b0000};
    tbl[4]  = '{12,  4'b0010};
    tbl[5]  = '{26,  4'b1010};
    tbl[6]  = '{48,  4'b0000};
    tbl[7]  = '{52,  4'b0000};
    tbl[8]  = '{64,  4'b0100};
    tbl[9]  = '{68,  4'b0110};
    tbl[10] = '{72,  4'b0100};
    tbl[11] = '{104, 4'b0110};
    tbl[12] = '{108, 4'b0100};
    tbl[13] = '{127, 4'b1100};
    tbl[14] = '{128, 4'b0001};

    // Hand-computed checkpoints for 12'hA5C with enable held.
    start(12'hA5C);
    begin
      int j = 0;
      for (int c = 0; c <= 128; c++) begin
        if (c > 0) step();
        if (j < 15 && tbl[j].cyc == c) begin
          check("a5c_table", c, outs(), tbl[j].exp);
          j++;
        end
      end
    end

    start(12'h800);
    run_scenario("neg_then_pos", 12'h800, 12'h7FF, -1, -1, 1'b0, 100000, 255);

    start(12'h123);
    run_scenario("drop_40", 12'h123, 12'h123, 40, -1, 1'b0, 128, 160);

    start(12'h5A5);
    run_scenario("drop40_restore60", 12'h5A5, 12'h5A5, 40, 60, 1'b0, 100000, 256);

    start(12'h6B1);
    run_scenario("one_cycle_pulse", 12'h6B1, 12'h6B1, 0, -1, 1'b0, 128, 150);

    start(12'hA5C);
    run_scenario("din_toggle", 12'hA5C, 12'h3C3, -1, -1, 1'b1, 100000, 255);

    // Asynchronous reset between clk edges mid-frame, enable left high.
    start(12'hA5C);
    run_scenario("pre_reset", 12'hA5C, 12'hA5C, -1, -1, 1'b0, 100000, 70);
    #2;
    reset_n = 1'b0;
    #1;
    check("midframe_reset_async", 70, outs(), 4'b0000);
    #2;
    reset_n = 1'b1;
    step();
    run_scenario("restart_after_reset", 12'hA5C, 12'hA5C, -1, -1, 1'b0, 100000, 130);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
